// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one NxN product over N iteration cycles,
// handed off as a registered 2N-bit P with a one-cycle done strobe.
module shift_add_mult #(
   parameter int N = 8
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             start,
   input  logic [N-1:0]     A,
   input  logic [N-1:0]     B,
   output logic             busy,
   output logic             done,
   output logic [2*N-1:0]   P
);

   localparam int             CW   = $clog2(N) + 1;
   localparam logic [CW-1:0]  LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [N-1:0]    mc;
   logic [N:0]      acc;
   logic [N-1:0]    mr;
   logic [CW-1:0]   cnt;
   logic [N:0]      sum;

   // acc[N] is always zero between iterations (the shift clears it), so adding the
   // full acc is the same as adding acc[N-1:0] and keeps the carry bit observable.
   always_comb begin
      sum = acc + (mr[0] ? {1'b0, mc} : '0);
   end

   // NOTE: every state register, including P, is cleared by CLR so an aborted
   // operation can never leave a partial product visible downstream.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         P     <= '0;
         mc    <= '0;
         acc   <= '0;
         mr    <= '0;
         cnt   <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values; the shift below depends on that.
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mc    <= A;
                  mr    <= B;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               {acc, mr} <= {1'b0, sum, mr[N-1:1]};
               cnt       <= cnt + CW'(1);
               if (cnt == LAST) begin
                  // post-shift {acc[N-1:0], mr} of the final iteration
                  P     <= {sum, mr[N-1:1]};
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
